tone_cmd_scheduler: RTL and testbench

- Front-end controller for the 4-channel tone datapath. Generates the free-running master sample counter that sequences the datapath.
- Assembles 3-byte host commands (address, data low, data high) and queues them in a small FIFO.
- Issues queued register writes to the datapath only in the safe window of each sample frame. Writes therefore never land during phase-accumulate, waveform-latch or mix slots.

---
 rtl/tone_cmd_scheduler.sv | 152 +++++++++++++++
 tb/tb_tone_cmd_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_cmd_scheduler.sv
// Tone datapath front-end: master sample counter, 3-byte host command
// assembly, command FIFO and safe-window write issue.
module tone_cmd_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int COUNT_MAX  = 1023
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic [7:0]  host_data_in,
  input  logic        host_strobe_in,
  input  logic        host_sync_in,
  output logic        host_ready_out,
  output logic        overflow_out,
  output logic [9:0]  master_count_out,
  output logic        frame_start_out,
  output logic [3:0]  addr_out,
  output logic [15:0] data_out,
  output logic        data_valid_out
);

  localparam int          PW       = $clog2(FIFO_DEPTH);
  localparam logic [9:0]  CNT_LAST = 10'(COUNT_MAX);
  localparam logic [9:0]  WIN_LO   = 10'd12;
  localparam logic [9:0]  WIN_HI   = 10'(COUNT_MAX - 1);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [3:0]  addr;
    logic [15:0] data;
  } cmd_t;

  typedef enum logic [1:0] {
    S_ADDR = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2
  } byte_state_t;

  byte_state_t   state_q, state_d;
  logic [3:0]    addr_q;
  logic [7:0]    lo_q;
  logic          ld_addr, ld_lo, push, ovf_set;

  cmd_t          fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   fifo_cnt;
  logic          fifo_full, fifo_empty, in_window, pop;

  assign fifo_full  = (fifo_cnt == FULL_CNT);
  assign fifo_empty = (fifo_cnt == '0);

  // Ready comes from FIFO state only; forced low while reset is held.
  assign host_ready_out = !reset_in && !fifo_full;

  // Frame start follows the registered counter; gated so it stays low in reset
  // yet flags the very first count-0 cycle after reset is released.
  assign frame_start_out = !reset_in && (master_count_out == 10'd0);

  // Writes are only safe outside the accumulate/latch/mix slots 0..11 and the
  // final slot, so the registered strobe lands in 13..COUNT_MAX.
  assign in_window = (master_count_out >= WIN_LO) && (master_count_out <= WIN_HI);
  assign pop       = !fifo_empty && in_window;

  // Free-running sample slot counter.
  always_ff @(posedge clk_in) begin
    if (reset_in)                          master_count_out <= '0;
    else if (master_count_out == CNT_LAST) master_count_out <= '0;
    else                                   master_count_out <= master_count_out + 10'd1;
  end

  // Byte FSM state, partial command latches and sticky overflow.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q      <= S_ADDR;
      addr_q       <= '0;
      lo_q         <= '0;
      overflow_out <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ld_addr) addr_q <= host_data_in[3:0];
      if (ld_lo)   lo_q   <= host_data_in;
      if (ovf_set) overflow_out <= 1'b1;
    end
  end

  // Byte FSM next state; sync beats strobe, strobe while not ready is an overflow.
  always_comb begin
    state_d = state_q;
    ld_addr = 1'b0;
    ld_lo   = 1'b0;
    push    = 1'b0;
    ovf_set = 1'b0;
    if (host_sync_in) begin
      state_d = S_ADDR;
    end else if (host_strobe_in && !host_ready_out) begin
      ovf_set = 1'b1;
    end else if (host_strobe_in) begin
      case (state_q)
        S_ADDR: begin
          ld_addr = 1'b1;
          state_d = S_LO;
        end
        S_LO: begin
          ld_lo   = 1'b1;
          state_d = S_HI;
        end
        S_HI: begin
          push    = 1'b1;
          state_d = S_ADDR;
        end
        default: state_d = S_ADDR;
      endcase
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk_in) begin
    if (push) fifo_mem[wr_ptr] <= '{addr: addr_q, data: {host_data_in, lo_q}};
  end

  // FIFO pointers and occupancy; power-of-two depth lets pointers wrap freely.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Datapath write port: one-cycle strobe, address/data hold between writes.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      addr_out       <= '0;
      data_out       <= '0;
      data_valid_out <= 1'b0;
    end else begin
      data_valid_out <= pop;
      if (pop) begin
        addr_out <= fifo_mem[rd_ptr].addr;
        data_out <= fifo_mem[rd_ptr].data;
      end
    end
  end

endmodule

// File: tb/tb_tone_cmd_scheduler.sv
module tb_tone_cmd_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  // instance A: default parameters
  logic [7:0]  a_data = '0;
  logic        a_stb = 1'b0, a_sync = 1'b0;
  logic        a_ready, a_ovf, a_fs, a_valid;
  logic [9:0]  a_cnt;
  logic [3:0]  a_addr;
  logic [15:0] a_dout;

  // instance B: short frame (COUNT_MAX=31)
  logic [7:0]  b_data = '0;
  logic        b_stb = 1'b0, b_sync = 1'b0;
  logic        b_ready, b_ovf, b_fs, b_valid;
  logic [9:0]  b_cnt;
  logic [3:0]  b_addr;
  logic [15:0] b_dout;

  tone_cmd_scheduler #(.FIFO_DEPTH(4), .COUNT_MAX(1023)) dut_a (
    .clk_in(clk), .reset_in(rst), .host_data_in(a_data), .host_strobe_in(a_stb),
    .host_sync_in(a_sync), .host_ready_out(a_ready), .overflow_out(a_ovf),
    .master_count_out(a_cnt), .frame_start_out(a_fs), .addr_out(a_addr),
    .data_out(a_dout), .data_valid_out(a_valid));

  tone_cmd_scheduler #(.FIFO_DEPTH(4), .COUNT_MAX(31)) dut_b (
    .clk_in(clk), .reset_in(rst), .host_data_in(b_data), .host_strobe_in(b_stb),
    .host_sync_in(b_sync), .host_ready_out(b_ready), .overflow_out(b_ovf),
    .master_count_out(b_cnt), .frame_start_out(b_fs), .addr_out(b_addr),
    .data_out(b_dout), .data_valid_out(b_valid));

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          cnt;
    logic [3:0]  addr;
    logic [15:0] data;
  } ev_t;
  ev_t evq_a[$];
  ev_t evq_b[$];

  // record every write strobe together with the slot it appeared in
  always @(negedge clk) begin
    if (a_valid === 1'b1) evq_a.push_back('{int'(a_cnt), a_addr, a_dout});
    if (b_valid === 1'b1) evq_b.push_back('{int'(b_cnt), b_addr, b_dout});
  end

  bit hit;

  // all waits/sends start and end on a negedge
  task automatic wait_cnt_a(input int c);
    hit = 1'b0;
    for (int i = 0; i < 2100; i++) begin
      if (int'(a_cnt) == c) begin hit = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_cnt_b(input int c);
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (int'(b_cnt) == c) begin hit = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic send_a(input logic [7:0] b);
    a_data = b; a_stb = 1'b1;
    @(negedge clk);
    a_stb = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] b);
    b_data = b; b_stb = 1'b1;
    @(negedge clk);
    b_stb = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (a_cnt !== 10'd0 || a_fs !== 1'b0 || a_addr !== 4'd0 || a_dout !== 16'd0 ||
        a_valid !== 1'b0 || a_ovf !== 1'b0 || a_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: cnt=%0d fs=%b addr=%h data=%h vld=%b ovf=%b rdy=%b required all 0",
               a_cnt, a_fs, a_addr, a_dout, a_valid, a_ovf, a_ready);
    end
    tests++;
    if (b_cnt !== 10'd0 || b_ready !== 1'b0 || b_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_state_b: cnt=%0d rdy=%b vld=%b required 0 0 0", b_cnt, b_ready, b_valid);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (a_cnt !== 10'd0 || a_fs !== 1'b1 || a_ready !== 1'b1) begin
      fails++;
      $display("FAIL first_frame: cnt=%0d fs=%b rdy=%b required 0 1 1", a_cnt, a_fs, a_ready);
    end
  endtask

  task automatic test_frames;
    int exp = 0;
    for (int i = 0; i < 2053; i++) begin
      @(negedge clk);
      exp = (exp == 1023) ? 0 : exp + 1;
      tests++;
      if (int'(a_cnt) != exp || a_fs !== (exp == 0) || a_valid !== 1'b0) begin
        fails++;
        $display("FAIL frame_count: cnt=%0d fs=%b vld=%b required cnt=%0d fs=%b vld=0",
                 a_cnt, a_fs, a_valid, exp, (exp == 0));
      end
    end
  endtask

  task automatic test_single_cmd;
    evq_a.delete();
    wait_cnt_a(5);
    send_a(8'h02); send_a(8'h34); send_a(8'h12);
    wait_cnt_a(20);
    tests++;
    if (!hit || evq_a.size() != 1) begin
      fails++;
      $display("FAIL single_cmd_count: writes=%0d required 1", evq_a.size());
    end else begin
      tests++;
      if (evq_a[0].cnt != 13 || evq_a[0].addr !== 4'h2 || evq_a[0].data !== 16'h1234) begin
        fails++;
        $display("FAIL single_cmd: slot=%0d addr=%h data=%h required slot=13 addr=2 data=1234",
                 evq_a[0].cnt, evq_a[0].addr, evq_a[0].data);
      end
    end
  endtask

  task automatic test_mid_window;
    evq_a.delete();
    wait_cnt_a(498);
    send_a(8'h0A); send_a(8'h78); send_a(8'h56);
    wait_cnt_a(510);
    tests++;
    if (!hit || evq_a.size() != 1) begin
      fails++;
      $display("FAIL mid_window_count: writes=%0d required 1", evq_a.size());
    end else begin
      tests++;
      if (evq_a[0].cnt != 502 || evq_a[0].addr !== 4'hA || evq_a[0].data !== 16'h5678) begin
        fails++;
        $display("FAIL mid_window: slot=%0d addr=%h data=%h required slot=502 addr=a data=5678",
                 evq_a[0].cnt, evq_a[0].addr, evq_a[0].data);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] abyte [5];
    logic [3:0] eaddr [4];
    abyte[0] = 8'hF3; abyte[1] = 8'h0C; abyte[2] = 8'h07; abyte[3] = 8'h5F; abyte[4] = 8'h09;
    eaddr[0] = 4'h3;  eaddr[1] = 4'hC;  eaddr[2] = 4'h7;  eaddr[3] = 4'hF;
    evq_a.delete();
    wait_cnt_a(1020);
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 3; j++) begin
        if (k == 3 && j == 2) begin
          tests++;
          if (a_ready !== 1'b1) begin
            fails++;
            $display("FAIL ready_before_full: rdy=%b required 1", a_ready);
          end
        end
        if (k == 4 && j == 0) begin
          tests++;
          if (a_ready !== 1'b0) begin
            fails++;
            $display("FAIL ready_when_full: rdy=%b required 0", a_ready);
          end
        end
        send_a(j == 0 ? abyte[k] : (j == 1 ? 8'h10 + 8'(k) : 8'hB0 + 8'(k)));
      end
    end
    wait_cnt_a(20);
    tests++;
    if (a_ovf !== 1'b1) begin
      fails++;
      $display("FAIL overflow_set: ovf=%b required 1", a_ovf);
    end
    tests++;
    if (!hit || evq_a.size() != 4) begin
      fails++;
      $display("FAIL b2b_count: writes=%0d required 4", evq_a.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        tests++;
        if (evq_a[k].cnt != 13 + k || evq_a[k].addr !== eaddr[k] ||
            evq_a[k].data !== {8'hB0 + 8'(k), 8'h10 + 8'(k)}) begin
          fails++;
          $display("FAIL b2b_entry%0d: slot=%0d addr=%h data=%h required slot=%0d addr=%h data=%h",
                   k, evq_a[k].cnt, evq_a[k].addr, evq_a[k].data, 13 + k, eaddr[k],
                   {8'hB0 + 8'(k), 8'h10 + 8'(k)});
        end
      end
    end
  endtask

  task automatic test_sync;
    evq_a.delete();
    @(negedge clk);
    send_a(8'h05); send_a(8'hAA);
    a_sync = 1'b1; a_data = 8'h33; a_stb = 1'b1;
    @(negedge clk);
    a_sync = 1'b0; a_stb = 1'b0;
    send_a(8'h01); send_a(8'hFF); send_a(8'h00);
    wait_cnt_a(30);
    tests++;
    if (a_ovf !== 1'b0) begin
      fails++;
      $display("FAIL sync_overflow: ovf=%b required 0", a_ovf);
    end
    tests++;
    if (!hit || evq_a.size() != 1) begin
      fails++;
      $display("FAIL sync_count: writes=%0d required 1", evq_a.size());
    end else begin
      tests++;
      if (evq_a[0].cnt != 13 || evq_a[0].addr !== 4'h1 || evq_a[0].data !== 16'h00FF) begin
        fails++;
        $display("FAIL sync_cmd: slot=%0d addr=%h data=%h required slot=13 addr=1 data=00ff",
                 evq_a[0].cnt, evq_a[0].addr, evq_a[0].data);
      end
    end
  endtask

  task automatic test_frame_edge;
    evq_b.delete();
    wait_cnt_b(28);
    send_b(8'h06); send_b(8'hCD); send_b(8'hAB);
    tests++;
    if (b_cnt !== 10'd31 || b_valid !== 1'b0) begin
      fails++;
      $display("FAIL edge_last_slot: cnt=%0d vld=%b required 31 0", b_cnt, b_valid);
    end
    @(negedge clk);
    tests++;
    if (b_cnt !== 10'd0 || b_fs !== 1'b1) begin
      fails++;
      $display("FAIL edge_wrap: cnt=%0d fs=%b required 0 1", b_cnt, b_fs);
    end
    wait_cnt_b(20);
    tests++;
    if (!hit || evq_b.size() != 1) begin
      fails++;
      $display("FAIL edge_count: writes=%0d required 1", evq_b.size());
    end else begin
      tests++;
      if (evq_b[0].cnt != 13 || evq_b[0].addr !== 4'h6 || evq_b[0].data !== 16'hABCD) begin
        fails++;
        $display("FAIL edge_cmd: slot=%0d addr=%h data=%h required slot=13 addr=6 data=abcd",
                 evq_b[0].cnt, evq_b[0].addr, evq_b[0].data);
      end
    end
  endtask

  task automatic test_reset_discard;
    evq_a.delete();
    evq_b.delete();
    wait_cnt_b(0);
    send_b(8'h01); send_b(8'h11); send_b(8'h22);
    send_b(8'h02); send_b(8'h33); send_b(8'h44);
    send_b(8'h03);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (b_ready !== 1'b0 || b_cnt !== 10'd0) begin
      fails++;
      $display("FAIL reset_mid_ready: rdy=%b cnt=%0d required 0 0", b_ready, b_cnt);
    end
    rst = 1'b0;
    repeat (80) @(negedge clk);
    tests++;
    if (evq_b.size() != 0 || evq_a.size() != 0) begin
      fails++;
      $display("FAIL reset_discard: writes_b=%0d writes_a=%0d required 0 0", evq_b.size(), evq_a.size());
    end
  endtask

  initial begin
    test_reset;
    test_frames;
    test_single_cmd;
    test_mid_window;
    test_back_to_back;
    test_reset;
    test_sync;
    test_frame_edge;
    test_reset_discard;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
